// File: rtl/muldiv_pkg.sv
// Shared widths, function codes and FSM state encoding for the mul/div scheduler.
// Latency: none (types and constants only).
// Backpressure: n/a.
package muldiv_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] CTRL_MUL = 4'b0010;
  localparam logic [CTRL_W-1:0] CTRL_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  // Only multiply and divide are executed by the shared unit.
  function automatic logic ctrl_legal(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == CTRL_MUL) || (ctrl == CTRL_DIV);
  endfunction
endpackage

// File: rtl/muldiv_scheduler_if.sv
// Bundle of requester, mul/div unit and CDB signals around the scheduler.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready and cdb_valid/cdb_ready handshakes.
interface muldiv_scheduler_if #(
  parameter int NREQ = 4
);
  import muldiv_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_x;
  logic [NREQ*DATA_W-1:0] req_y;
  logic [NREQ*CTRL_W-1:0] req_ctrl;
  logic [NREQ*TAG_W-1:0]  req_save_no;
  logic [NREQ*TAG_W-1:0]  req_rob;

  logic                   alu_start;
  logic [DATA_W-1:0]      alu_x;
  logic [DATA_W-1:0]      alu_y;
  logic [CTRL_W-1:0]      alu_ctrl;
  logic                   alu_done;
  logic [DATA_W-1:0]      alu_result;

  logic                   cdb_valid;
  logic                   cdb_ready;
  logic [DATA_W-1:0]      cdb_result;
  logic [TAG_W-1:0]       cdb_save_no;
  logic [TAG_W-1:0]       cdb_rob;
  logic                   cdb_err;

  // Scheduler side.
  modport master (
    input  req_valid, req_x, req_y, req_ctrl, req_save_no, req_rob,
    input  alu_done, alu_result, cdb_ready,
    output req_ready, alu_start, alu_x, alu_y, alu_ctrl,
    output cdb_valid, cdb_result, cdb_save_no, cdb_rob, cdb_err
  );

  // Requesters, mul/div unit and CDB consumer side.
  modport slave (
    output req_valid, req_x, req_y, req_ctrl, req_save_no, req_rob,
    output alu_done, alu_result, cdb_ready,
    input  req_ready, alu_start, alu_x, alu_y, alu_ctrl,
    input  cdb_valid, cdb_result, cdb_save_no, cdb_rob, cdb_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of one request, searching from the index after ptr.
// Latency: combinational.
// Backpressure: none; caller decides when the grant is used.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_idx
);
  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk ptr+1 .. ptr+NREQ (wrapping) and take the first asserted request.
  always_comb begin
    grant     = '0;
    grant_idx = ptr;
    idx       = '0;
    found     = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/muldiv_scheduler.sv
// Round-robin issue of reservation-station ops to one shared mul/div unit, result onto the CDB.
// Latency: accept at T, alu_start at T+1, alu_done at T+1+k, cdb_valid from T+2+k.
// Backpressure: CDB outputs held until cdb_ready; no grant while an op is in flight.
// Optional WAIT watchdog enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_scheduler
  import muldiv_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  muldiv_scheduler_if.master bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  // A zero limit would make the watchdog meaningless.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("muldiv_scheduler: TIMEOUT must be at least 1");
  end

  state_t            state, state_nxt;
  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ready;
  logic              start, cdb_vld;
  logic              accept, done_hit, fail;
  logic              wd_fire;

  logic [DATA_W-1:0] x_q, y_q, res_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [TAG_W-1:0]  save_q, rob_q;
  logic              err_q;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

`ifdef MULDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt;

  // Count WAIT cycles; any other state clears it so every WAIT entry starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               wd_cnt <= '0;
    else if (state != WAIT) wd_cnt <= '0;
    else                    wd_cnt <= wd_cnt + 1'b1;
  end

  assign wd_fire = (state == WAIT) && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign wd_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and handshake strobes; flush overrides everything, including a same-cycle alu_done.
  always_comb begin
    state_nxt = state;
    ready     = '0;
    start     = 1'b0;
    cdb_vld   = 1'b0;
    accept    = 1'b0;
    done_hit  = 1'b0;
    fail      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          ready     = gnt;
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
        ISSUE: if (ctrl_legal(ctrl_q)) begin
          start     = 1'b1;
          state_nxt = WAIT;
        end else begin
          fail      = 1'b1;
          state_nxt = WB;
        end
        WAIT: if (bus.alu_done) begin
          done_hit  = 1'b1;
          state_nxt = WB;
        end else if (wd_fire) begin
          fail      = 1'b1;
          state_nxt = WB;
        end
        WB: begin
          cdb_vld = 1'b1;
          if (bus.cdb_ready) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand/tag capture on accept, result/error capture on completion; pointer moves only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= PTR_W'(NREQ - 1);
      x_q    <= '0;
      y_q    <= '0;
      ctrl_q <= '0;
      save_q <= '0;
      rob_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        rr_ptr <= gnt_idx;
        x_q    <= bus.req_x[gnt_idx*DATA_W +: DATA_W];
        y_q    <= bus.req_y[gnt_idx*DATA_W +: DATA_W];
        ctrl_q <= bus.req_ctrl[gnt_idx*CTRL_W +: CTRL_W];
        save_q <= bus.req_save_no[gnt_idx*TAG_W +: TAG_W];
        rob_q  <= bus.req_rob[gnt_idx*TAG_W +: TAG_W];
      end
      if (done_hit) begin
        res_q <= bus.alu_result;
        err_q <= 1'b0;
      end else if (fail) begin
        res_q <= '0;
        err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.alu_start   = start;
  assign bus.alu_x       = x_q;
  assign bus.alu_y       = y_q;
  assign bus.alu_ctrl    = ctrl_q;
  assign bus.cdb_valid   = cdb_vld;
  assign bus.cdb_result  = res_q;
  assign bus.cdb_save_no = save_q;
  assign bus.cdb_rob     = rob_q;
  assign bus.cdb_err     = err_q;
endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed bench for muldiv_scheduler: reset, single op, fairness, backpressure, illegal ctrl, flush, watchdog.
// The bench plays the requesters, the mul/div unit and the CDB consumer.
// Inputs change just after the falling edge and outputs are sampled 1 time unit later.
module tb_muldiv_scheduler;
  import muldiv_pkg::*;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [DATA_W-1:0] rx [NREQ];
  logic [DATA_W-1:0] ry [NREQ];
  logic [CTRL_W-1:0] rc [NREQ];
  logic [TAG_W-1:0]  rs [NREQ];
  logic [TAG_W-1:0]  rr [NREQ];
  logic [DATA_W-1:0] got;

  muldiv_scheduler_if #(.NREQ(NREQ)) bus ();

  muldiv_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                         input logic [CTRL_W-1:0] c, input logic [TAG_W-1:0] s,
                         input logic [TAG_W-1:0] r);
    rx[i] = x; ry[i] = y; rc[i] = c; rs[i] = s; rr[i] = r;
    bus.req_x[i*DATA_W +: DATA_W]      = x;
    bus.req_y[i*DATA_W +: DATA_W]      = y;
    bus.req_ctrl[i*CTRL_W +: CTRL_W]   = c;
    bus.req_save_no[i*TAG_W +: TAG_W]  = s;
    bus.req_rob[i*TAG_W +: TAG_W]      = r;
    bus.req_valid[i]                   = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; flush = 1'b0;
    bus.req_valid = '0; bus.alu_done = 1'b0; bus.cdb_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
  endtask

  // One legal op: expects grant g now (or within a bounded wait), unit answers k cycles after
  // alu_start, the consumer stalls 'hold' cycles in WB. Starts and ends at a sample point in IDLE.
  task automatic do_op(input string tag, input int g, input int k, input int hold,
                       input bit keep, output logic [DATA_W-1:0] res_out);
    logic [DATA_W-1:0] res;
    int n;
    n = 0;
    while (bus.req_ready == '0 && n < 16) begin tick(); #1; n++; end
    check({tag, "_gnt"}, 64'(bus.req_ready), 64'd1 << g);
    res = (rc[g] == CTRL_MUL) ? rx[g] * ry[g] : rx[g] / ry[g];
    tick();
    if (!keep) bus.req_valid[g] = 1'b0;
    #1;
    check({tag, "_start"}, 64'(bus.alu_start), 64'd1);
    check({tag, "_x"}, 64'(bus.alu_x), 64'(rx[g]));
    check({tag, "_y"}, 64'(bus.alu_y), 64'(ry[g]));
    check({tag, "_ctrl"}, 64'(bus.alu_ctrl), 64'(rc[g]));
    check({tag, "_rdy_issue"}, 64'(bus.req_ready), 64'd0);
    for (int c = 1; c <= k; c++) begin
      tick();
      if (c == k) begin bus.alu_done = 1'b1; bus.alu_result = res; end
      #1;
      if (c == 1) check({tag, "_start_once"}, 64'(bus.alu_start), 64'd0);
    end
    tick();
    bus.alu_done = 1'b0; bus.alu_result = 32'hdead_beef;
    #1;
    check({tag, "_vld"}, 64'(bus.cdb_valid), 64'd1);
    check({tag, "_res"}, 64'(bus.cdb_result), 64'(res));
    check({tag, "_save"}, 64'(bus.cdb_save_no), 64'(rs[g]));
    check({tag, "_rob"}, 64'(bus.cdb_rob), 64'(rr[g]));
    check({tag, "_err"}, 64'(bus.cdb_err), 64'd0);
    res_out = bus.cdb_result;
    for (int c = 0; c < hold; c++) begin
      tick(); #1;
      check({tag, "_hold_vld"}, 64'(bus.cdb_valid), 64'd1);
      check({tag, "_hold_res"}, 64'(bus.cdb_result), 64'(res));
      check({tag, "_hold_rob"}, 64'(bus.cdb_rob), 64'(rr[g]));
      check({tag, "_hold_rdy"}, 64'(bus.req_ready), 64'd0);
    end
    bus.cdb_ready = 1'b1;
    #1;
    check({tag, "_rdy_hs"}, 64'(bus.req_ready), 64'd0);
    tick();
    bus.cdb_ready = 1'b0;
    #1;
    check({tag, "_vld_done"}, 64'(bus.cdb_valid), 64'd0);
  endtask

  initial begin
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.req_ctrl = '0;
    bus.req_save_no = '0; bus.req_rob = '0;
    bus.alu_done = 1'b0; bus.alu_result = '0; bus.cdb_ready = 1'b0;

    // Reset values.
    tick(); #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_alu_start", 64'(bus.alu_start), 64'd0);
    check("rst_alu_x", 64'(bus.alu_x), 64'd0);
    check("rst_alu_y", 64'(bus.alu_y), 64'd0);
    check("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    check("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    check("rst_cdb_result", 64'(bus.cdb_result), 64'd0);
    check("rst_cdb_save_no", 64'(bus.cdb_save_no), 64'd0);
    check("rst_cdb_rob", 64'(bus.cdb_rob), 64'd0);
    check("rst_cdb_err", 64'(bus.cdb_err), 64'd0);
    tick(); rst = 1'b1; #1;

    // Single request: 6*7, unit answers 3 cycles after alu_start.
    set_req(0, 32'd6, 32'd7, CTRL_MUL, 5'd3, 5'd17);
    #1;
    do_op("single", 0, 3, 0, 1'b0, got);
    check("single_42", 64'(got), 64'd42);

    // Fairness: all four held valid from reset, expected order 0,1,2,3,0.
    do_reset();
    set_req(0, 32'd2, 32'd10, CTRL_MUL, 5'd1, 5'd4);
    set_req(1, 32'd3, 32'd11, CTRL_MUL, 5'd2, 5'd5);
    set_req(2, 32'd50, 32'd5, CTRL_DIV, 5'd3, 5'd6);
    set_req(3, 32'd4, 32'd13, CTRL_MUL, 5'd4, 5'd7);
    #1;
    do_op("fair0", 0, 1, 0, 1'b1, got);
    do_op("fair1", 1, 2, 0, 1'b1, got);
    do_op("fair2", 2, 1, 0, 1'b1, got);
    do_op("fair3", 3, 1, 0, 1'b1, got);
    do_op("fair4", 0, 1, 0, 1'b1, got);
    bus.req_valid = '0;

    // Backpressure: 100/7 with 5 stalled WB cycles (pointer at 0, only requester 2 valid).
    set_req(2, 32'd100, 32'd7, CTRL_DIV, 5'd9, 5'd22);
    #1;
    do_op("bp", 2, 2, 5, 1'b0, got);
    check("bp_14", 64'(got), 64'd14);

    // Illegal ctrl: no ALU start, error result one cycle after ISSUE.
    set_req(1, 32'd5, 32'd5, 4'b0111, 5'd4, 5'd11);
    #1;
    check("ill_gnt", 64'(bus.req_ready), 64'b0010);
    tick(); bus.req_valid = '0; #1;
    check("ill_start_issue", 64'(bus.alu_start), 64'd0);
    check("ill_vld_issue", 64'(bus.cdb_valid), 64'd0);
    tick(); #1;
    check("ill_start_wb", 64'(bus.alu_start), 64'd0);
    check("ill_vld", 64'(bus.cdb_valid), 64'd1);
    check("ill_err", 64'(bus.cdb_err), 64'd1);
    check("ill_res", 64'(bus.cdb_result), 64'd0);
    check("ill_rob", 64'(bus.cdb_rob), 64'd11);
    bus.cdb_ready = 1'b1;
    tick(); bus.cdb_ready = 1'b0; #1;
    check("ill_vld_done", 64'(bus.cdb_valid), 64'd0);

    // Flush in WAIT together with alu_done: result dropped, pointer stays at 2.
    set_req(2, 32'd9, 32'd9, CTRL_MUL, 5'd6, 5'd7);
    #1;
    check("fl_gnt", 64'(bus.req_ready), 64'b0100);
    tick(); bus.req_valid = '0; #1;
    check("fl_start", 64'(bus.alu_start), 64'd1);
    tick(); #1;
    check("fl_wait_vld", 64'(bus.cdb_valid), 64'd0);
    tick(); flush = 1'b1; bus.alu_done = 1'b1; bus.alu_result = 32'd81; #1;
    check("fl_start_f", 64'(bus.alu_start), 64'd0);
    check("fl_vld_f", 64'(bus.cdb_valid), 64'd0);
    tick(); flush = 1'b0; bus.alu_done = 1'b0; #1;
    check("fl_vld_after", 64'(bus.cdb_valid), 64'd0);
    check("fl_idle_rdy", 64'(bus.req_ready), 64'd0);
    tick();
    flush = 1'b1;
    set_req(0, 32'd1, 32'd1, CTRL_MUL, 5'd1, 5'd1);
    set_req(1, 32'd1, 32'd1, CTRL_MUL, 5'd1, 5'd1);
    set_req(2, 32'd1, 32'd1, CTRL_MUL, 5'd1, 5'd1);
    set_req(3, 32'd12, 32'd4, CTRL_DIV, 5'd8, 5'd30);
    #1;
    check("fl_nogrant", 64'(bus.req_ready), 64'd0);
    tick(); flush = 1'b0; #1;
    check("fl_next_gnt", 64'(bus.req_ready), 64'b1000);
    bus.req_valid = 4'b1000;
    #1;
    do_op("post_fl", 3, 2, 0, 1'b0, got);
    check("post_fl_3", 64'(got), 64'd3);

    // Watchdog: unit never answers.
    set_req(0, 32'd3, 32'd3, CTRL_MUL, 5'd2, 5'd1);
    #1;
    check("to_gnt", 64'(bus.req_ready), 64'b0001);
    tick(); bus.req_valid = '0; #1;
    check("to_start", 64'(bus.alu_start), 64'd1);
    for (int c = 1; c <= TIMEOUT; c++) begin
      tick(); #1;
      check("to_wait_vld", 64'(bus.cdb_valid), 64'd0);
    end
`ifdef MULDIV_TIMEOUT_EN
    tick(); #1;
    check("to_vld", 64'(bus.cdb_valid), 64'd1);
    check("to_err", 64'(bus.cdb_err), 64'd1);
    check("to_res", 64'(bus.cdb_result), 64'd0);
    check("to_rob", 64'(bus.cdb_rob), 64'd1);
    bus.cdb_ready = 1'b1;
    tick(); bus.cdb_ready = 1'b0; #1;
    check("to_vld_done", 64'(bus.cdb_valid), 64'd0);
`else
    for (int c = 0; c < 12; c++) begin
      tick(); #1;
      check("to_hold_vld", 64'(bus.cdb_valid), 64'd0);
    end
    // Reset while stuck in WAIT drops the op.
    rst = 1'b0; #1;
    check("rw_alu_x", 64'(bus.alu_x), 64'd0);
    check("rw_vld", 64'(bus.cdb_valid), 64'd0);
    tick(); rst = 1'b1; tick(); #1;
    check("rw_vld_after", 64'(bus.cdb_valid), 64'd0);
    check("rw_rdy_after", 64'(bus.req_ready), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if the bench ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/muldiv_scheduler.md
MULDIV_SCHEDULER -- requirements
Module: muldiv_scheduler

Interface
REQ-001 Parameter NREQ, default 4: number of reservation-station requesters.
REQ-002 Parameter TIMEOUT, default 64: watchdog limit in cycles; used only when MULDIV_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 flush  in  1  synchronous abort of the in-flight operation.
REQ-006 req_valid  in  NREQ  per-requester operation-pending flag.
REQ-007 req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i]&req_ready[i].
REQ-008 req_x, req_y  in  NREQ*32 each  operand A and operand B, packed by requester index.
REQ-009 req_ctrl  in  NREQ*4  function code per requester.
REQ-010 req_save_no, req_rob  in  NREQ*5 each  reservation-station number and destination ROB tag.
REQ-011 alu_start  out  1  drives the shared mul/div unit's data_ready input.
REQ-012 alu_x, alu_y  out  32 each  latched operands; alu_ctrl  out  4  latched function code.
REQ-013 alu_done  in  1  completion from the unit; alu_result  in  32  result from the unit.
REQ-014 cdb_valid  out  1  result available; cdb_ready  in  1  consumer accepts.
REQ-015 cdb_result  out  32; cdb_save_no, cdb_rob  out  5 each; cdb_err  out  1  error flag (illegal ctrl or timeout).

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, WB.
REQ-017 IDLE: if any req_valid is set, grant exactly one requester by round-robin, starting at the index after the last granted one; assert that requester's req_ready for one cycle; latch x, y, ctrl, save_no and rob; go to ISSUE.
REQ-018 req_ready is 0 in every state other than IDLE; at most one bit is set at a time.
REQ-019 ISSUE with ctrl 4'b0010 (mul) or 4'b0011 (div): alu_start=1 for exactly one cycle, then go to WAIT.
REQ-020 ISSUE with any other ctrl: the ALU is not started; go to WB with cdb_result=0 and cdb_err=1.
REQ-021 alu_x, alu_y and alu_ctrl hold the latched values from ISSUE until the FSM leaves WAIT.
REQ-022 WAIT: when alu_done=1, latch alu_result into cdb_result with cdb_err=0, then go to WB; alu_done is ignored in all other states.
REQ-023 WB: cdb_valid=1 and the cdb_* outputs stay stable until cdb_ready=1; on that handshake cycle return to IDLE, with no new grant in the same cycle.
REQ-024 Minimum latency: accept at cycle T, alu_start at T+1, alu_done at T+1+k, cdb_valid from T+2+k.
REQ-025 flush=1 in any state: next state is IDLE, cdb_valid=0, alu_start=0, no grant that cycle; the round-robin pointer is unchanged.
REQ-026 flush and alu_done in the same cycle: flush wins and the result is discarded.
REQ-027 Round-robin pointer wraps from NREQ-1 to 0 and updates only on an accepted transfer.

Reset
REQ-028 On rst=0: state=IDLE, round-robin pointer=NREQ-1 so that index 0 has first priority.
REQ-029 On rst=0, all outputs are 0: req_ready, alu_start, alu_x, alu_y, alu_ctrl, cdb_valid, cdb_result, cdb_save_no, cdb_rob, cdb_err.
REQ-030 Reset during WAIT or WB drops the in-flight operation with no result emitted.

Configuration
REQ-031 Macro MULDIV_TIMEOUT_EN controls a watchdog.
REQ-032 With MULDIV_TIMEOUT_EN defined: a cycle counter runs in WAIT; after TIMEOUT cycles without alu_done, go to WB with cdb_result=0 and cdb_err=1; the counter clears on entry to WAIT.
REQ-033 Without MULDIV_TIMEOUT_EN: WAIT holds indefinitely, no counter logic exists, and cdb_err is set only by an illegal ctrl.

Structure
REQ-034 Shared package muldiv_pkg holds: DATA_W=32, TAG_W=5, CTRL_W=4, CTRL_MUL=4'b0010, CTRL_DIV=4'b0011, and the FSM state typedef.
REQ-035 Sub-module rr_arbiter (NREQ-wide, request vector plus pointer in, one-hot grant out) holds the round-robin selection.

Verification
REQ-036 Single request: req_valid=4'b0001, ctrl=MUL, x=6, y=7, alu_done 3 cycles after alu_start -> cdb_result=42, cdb_rob echoed, cdb_err=0.
REQ-037 Fairness: all four requesters valid continuously -> grant order 0,1,2,3,0; no requester is granted twice before the others are served.
REQ-038 Backpressure: cdb_ready=0 for 5 cycles in WB -> cdb_valid and the cdb_* outputs stay stable and req_ready stays 0 throughout.
REQ-039 Illegal ctrl 4'b0111 -> alu_start never rises; cdb_valid with cdb_err=1 and cdb_result=0.
REQ-040 flush asserted in WAIT, with alu_done in the same cycle -> no cdb_valid, FSM in IDLE, next grant follows the unchanged pointer.
REQ-041 MULDIV_TIMEOUT_EN with TIMEOUT=8 and alu_done never asserted -> cdb_err=1 exactly 8 cycles after entering WAIT; without the macro, cdb_valid stays 0.
